// File: rtl/sr_run_ctrl_pkg.sv
// Shared definitions for the sr_run_ctrl run-control sequencer:
// host command opcodes, sequencer states and a legality helper.
package sr_run_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_HALT      = 3'd1,
        OP_RUN       = 3'd2,
        OP_STEP      = 3'd3,
        OP_SET_BP    = 3'd4,
        OP_CLR_BP    = 3'd5,
        OP_LOAD      = 3'd6,
        OP_RESET_CPU = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_CRST   = 3'd4
    } state_e;

    // While free-running the core only NOP and HALT make sense.
    function automatic logic run_legal(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/sr_bp_unit.sv
// Single instruction breakpoint for sr_run_ctrl.
// Ports: clk/rst (sync, active high); set/clr load or drop the breakpoint
// at set_addr; enter marks entry into RUN/STEP; en is the core enable;
// pc is the core word PC; match flags a breakpoint hit this cycle.
module sr_bp_unit
    import sr_run_ctrl_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic          clr,
    input  logic          enter,
    input  logic          en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] pc,
    output logic          match
);

    logic [AW-1:0] bp_addr;
    logic          bp_valid;
    logic          first;

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_addr  <= '0;
            bp_valid <= 1'b0;
            first    <= 1'b0;
        end else begin
            if (set) begin
                bp_addr  <= set_addr;
                bp_valid <= 1'b1;
            end else if (clr) begin
                bp_valid <= 1'b0;
            end
            // Masking the first executed instruction lets a resume
            // step over the breakpoint it stopped on.
            if (enter)
                first <= 1'b1;
            else if (en)
                first <= 1'b0;
        end
    end

    assign match = bp_valid && (pc == bp_addr) && !first;

endmodule

// File: rtl/sr_run_ctrl.sv
// Run-control sequencer for the single-cycle RISC-V core: halt, run,
// N-instruction step, one breakpoint and host program load.
// Ports: clk, rst (sync, active high); cmd_valid/cmd_ready/cmd_op/
// cmd_addr/cmd_data host command port; cmd_err illegal-op pulse;
// cpu_pc core PC in; cpu_en, cpu_rst_n core controls; imem_we/
// imem_waddr/imem_wdata instruction-memory write port; halted, bp_hit
// status; instr_cnt retired count.
// Optional: define SR_RUN_CTRL_INSTR_CNT_EN to build the retired-
// instruction counter; otherwise instr_cnt is tied to zero.
module sr_run_ctrl
    import sr_run_ctrl_pkg::*;
#(
    parameter int AW     = 8,
    parameter int STEP_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_data,
    output logic          cmd_err,
    input  logic [AW-1:0] cpu_pc,
    output logic          cpu_en,
    output logic          cpu_rst_n,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          halted,
    output logic          bp_hit,
    output logic [31:0]   instr_cnt
);

    state_e state;
    state_e state_nxt;

    logic              match;
    logic              rst_done;
    logic              halt_req;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_n;

    logic err_nxt;
    logic set_bp;
    logic clr_bp;
    logic enter;
    logic ld;
    logic crst;
    logic step_load;
    logic hit_set;
    logic hit_clr;

    assign halt_req = cmd_valid && (cmd_op == OP_HALT);
    assign step_n   = cmd_data[STEP_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_HALTED;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cpu_en    = 1'b0;
        err_nxt   = 1'b0;
        set_bp    = 1'b0;
        clr_bp    = 1'b0;
        enter     = 1'b0;
        ld        = 1'b0;
        crst      = 1'b0;
        step_load = 1'b0;
        hit_set   = 1'b0;
        hit_clr   = 1'b0;
        unique case (state)
            ST_HALTED: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_RUN: begin
                            state_nxt = ST_RUN;
                            enter     = 1'b1;
                            hit_clr   = 1'b1;
                        end
                        OP_STEP: begin
                            state_nxt = ST_STEP;
                            enter     = 1'b1;
                            hit_clr   = 1'b1;
                            step_load = 1'b1;
                        end
                        OP_SET_BP: set_bp = 1'b1;
                        OP_CLR_BP: clr_bp = 1'b1;
                        OP_LOAD: begin
                            state_nxt = ST_LOAD;
                            ld        = 1'b1;
                        end
                        OP_RESET_CPU: begin
                            state_nxt = ST_CRST;
                            crst      = 1'b1;
                            hit_clr   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cmd_ready = 1'b1;
                // A HALT stops the core in its own acceptance cycle.
                cpu_en    = !match && !halt_req;
                err_nxt   = cmd_valid && !run_legal(cmd_op);
                if (match) begin
                    state_nxt = ST_HALTED;
                    hit_set   = 1'b1;
                end else if (halt_req) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_STEP: begin
                cpu_en = !match;
                if (match) begin
                    state_nxt = ST_HALTED;
                    hit_set   = 1'b1;
                end else if (step_cnt <= STEP_W'(1)) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_LOAD: state_nxt = ST_HALTED;
            ST_CRST: state_nxt = ST_HALTED;
            default: state_nxt = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_done   <= 1'b0;
            cmd_err    <= 1'b0;
            bp_hit     <= 1'b0;
            step_cnt   <= '0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            rst_done <= 1'b1;
            cmd_err  <= err_nxt;
            if (hit_set)
                bp_hit <= 1'b1;
            else if (hit_clr)
                bp_hit <= 1'b0;
            if (ld) begin
                imem_waddr <= cmd_addr;
                imem_wdata <= cmd_data;
            end
            // A zero count still executes one instruction.
            if (step_load)
                step_cnt <= (step_n == '0) ? STEP_W'(1) : step_n;
            else if (hit_set)
                step_cnt <= '0;
            else if (cpu_en && (step_cnt != '0))
                step_cnt <= step_cnt - STEP_W'(1);
        end
    end

    assign halted    = (state == ST_HALTED);
    assign imem_we   = (state == ST_LOAD);
    assign cpu_rst_n = rst_done && (state != ST_CRST);

    sr_bp_unit #(
        .AW(AW)
    ) u_bp (
        .clk      (clk),
        .rst      (rst),
        .set      (set_bp),
        .clr      (clr_bp),
        .enter    (enter),
        .en       (cpu_en),
        .set_addr (cmd_addr),
        .pc       (cpu_pc),
        .match    (match)
    );

`ifdef SR_RUN_CTRL_INSTR_CNT_EN
    logic [31:0] icnt;

    always_ff @(posedge clk) begin
        if (rst || crst)
            icnt <= '0;
        else if (cpu_en)
            icnt <= icnt + 32'd1;
    end

    assign instr_cnt = icnt;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_run_ctrl.sv
// Self-checking bench for sr_run_ctrl with a simple core model whose PC
// advances by one word on every enabled cycle.
module tb_sr_run_ctrl;
    import sr_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_addr = 8'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_err;
    logic [7:0]  pc;
    logic        cpu_en;
    logic        cpu_rst_n;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        halted;
    logic        bp_hit;
    logic [31:0] instr_cnt;

    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    sr_run_ctrl #(.AW(8), .STEP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_err    (cmd_err),
        .cpu_pc     (pc),
        .cpu_en     (cpu_en),
        .cpu_rst_n  (cpu_rst_n),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .instr_cnt  (instr_cnt)
    );

    // Core model: reset clears the PC, each enabled cycle retires one word.
    always @(posedge clk) begin
        if (!cpu_rst_n) pc <= 8'd0;
        else if (cpu_en) pc <= pc + 8'd1;
    end

    always @(posedge clk) begin
        if (cpu_en) en_cnt++;
        if (cmd_err) err_cnt++;
        if (imem_we) we_cnt++;
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a,
                         input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL issue_ready op=%0d got=%b exp=1", op, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = a;
        cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = OP_NOP;
    endtask

    task automatic wait_halted();
        int n = 0;
        while (!halted && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!halted) begin
            total++; bad++;
            $display("FAIL wait_halted got=0 exp=1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL rst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL rst_halted got=%b exp=1", halted); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_cpu_en got=%b exp=0", cpu_en); end
        total++; if ({imem_we, cmd_err, bp_hit} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {imem_we, cmd_err, bp_hit}); end
        total++; if ({imem_waddr, imem_wdata} !== 40'd0) begin bad++; $display("FAIL rst_imem got=%h exp=0", {imem_waddr, imem_wdata}); end
        total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL rst_instr_cnt got=%0d exp=0", instr_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL rel_cpu_rst_n got=%b exp=1", cpu_rst_n); end
        total++; if ({halted, cpu_en, cmd_ready} !== 3'b101) begin bad++; $display("FAIL rel_state got=%b exp=101", {halted, cpu_en, cmd_ready}); end
    endtask

    task automatic test_load();
        logic [7:0] a;
        logic [31:0] d;
        int w0;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 8'h05 : 8'($urandom);
            d = (i == 0) ? 32'h00500093 : $urandom;
            w0 = we_cnt;
            issue(OP_LOAD, a, d);
            total++; if ({imem_we, cmd_ready} !== 2'b10) begin bad++; $display("FAIL load_t1 we_ready got=%b exp=10", {imem_we, cmd_ready}); end
            total++; if (imem_waddr !== a || imem_wdata !== d) begin bad++; $display("FAIL load_t1 addr_data got=%h/%h exp=%h/%h", imem_waddr, imem_wdata, a, d); end
            @(posedge clk); #1;
            total++; if ({imem_we, cmd_ready, halted} !== 3'b011) begin bad++; $display("FAIL load_t2 got=%b exp=011", {imem_we, cmd_ready, halted}); end
            total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL load_we_cycles got=%0d exp=1", we_cnt - w0); end
        end
    endtask

    task automatic test_step();
        int n;
        int e;
        int e0;
        logic [7:0] p0;
        issue(OP_CLR_BP, 8'd0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            n = (i < 4) ? ((i == 0) ? 3 : i - 1) : int'($urandom_range(0, 40));
            e = (n == 0) ? 1 : n;
            p0 = pc;
            e0 = en_cnt;
            issue(OP_STEP, 8'd0, {16'($urandom), 16'(n)});
            wait_halted();
            total++; if (en_cnt - e0 !== e) begin bad++; $display("FAIL step_count n=%0d got=%0d exp=%0d", n, en_cnt - e0, e); end
            total++; if (pc !== 8'(p0 + 8'(e)) || bp_hit !== 1'b0) begin bad++; $display("FAIL step_pc got=%0d/%b exp=%0d/0", pc, bp_hit, 8'(p0 + 8'(e))); end
        end
    endtask

    task automatic test_breakpoint();
        int d;
        int m;
        int e0;
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            d = $urandom_range(1, 30);
            b = pc + 8'(d);
            issue(OP_SET_BP, b, 32'd0);
            e0 = en_cnt;
            issue(OP_RUN, 8'd0, 32'd0);
            wait_halted();
            total++; if (en_cnt - e0 !== d) begin bad++; $display("FAIL bp_run_count got=%0d exp=%0d", en_cnt - e0, d); end
            total++; if ({pc, bp_hit, cpu_en} !== {b, 2'b10}) begin bad++; $display("FAIL bp_stop pc/hit/en got=%0d/%b/%b exp=%0d/1/0", pc, bp_hit, cpu_en, b); end
            m = $urandom_range(1, 10);
            e0 = en_cnt;
            issue(OP_RUN, 8'd0, 32'd0);
            total++; if ({bp_hit, cpu_en, pc} !== {2'b01, b}) begin bad++; $display("FAIL bp_resume hit/en/pc got=%b/%b/%0d exp=0/1/%0d", bp_hit, cpu_en, pc, b); end
            repeat (m) @(posedge clk);
            issue(OP_HALT, 8'd0, 32'd0);
            total++; if (en_cnt - e0 !== m || halted !== 1'b1) begin bad++; $display("FAIL bp_halt count/halted got=%0d/%b exp=%0d/1", en_cnt - e0, halted, m); end
        end
    endtask

    task automatic test_step_bp();
        int d;
        int n;
        int e;
        int e0;
        logic [7:0] p0;
        logic h;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(1, 12);
            n = $urandom_range(1, 12);
            e = (d < n) ? d : n;
            h = (d < n);
            p0 = pc;
            issue(OP_SET_BP, p0 + 8'(d), 32'd0);
            e0 = en_cnt;
            issue(OP_STEP, 8'd0, 32'(n));
            wait_halted();
            total++; if (en_cnt - e0 !== e || bp_hit !== h) begin bad++; $display("FAIL step_bp d=%0d n=%0d got=%0d/%b exp=%0d/%b", d, n, en_cnt - e0, bp_hit, e, h); end
        end
    endtask

    task automatic test_run_err();
        int w0;
        int r0;
        logic [2:0] ops [5];
        ops = '{OP_STEP, OP_SET_BP, OP_CLR_BP, OP_LOAD, OP_RESET_CPU};
        issue(OP_CLR_BP, 8'd0, 32'd0);
        issue(OP_RUN, 8'd0, 32'd0);
        w0 = we_cnt;
        for (int i = 0; i < 5; i++) begin
            issue(ops[$urandom_range(0, 4)], 8'($urandom), $urandom);
            total++; if ({cmd_err, halted, cpu_en} !== 3'b101) begin bad++; $display("FAIL run_err t1 err/halt/en got=%b exp=101", {cmd_err, halted, cpu_en}); end
            @(posedge clk); #1;
            total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL run_err_pulse got=%b exp=0", cmd_err); end
        end
        r0 = err_cnt;
        issue(OP_NOP, 8'd0, 32'd0);
        @(posedge clk); #1;
        total++; if (err_cnt - r0 !== 0 || we_cnt - w0 !== 0) begin bad++; $display("FAIL run_err_side err/we got=%0d/%0d exp=0/0", err_cnt - r0, we_cnt - w0); end
        issue(OP_HALT, 8'd0, 32'd0);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL run_halt got=%b exp=1", halted); end
    endtask

    task automatic test_halt_bp_same();
        int d;
        int e0;
        logic [7:0] b;
        d = $urandom_range(2, 10);
        b = pc + 8'(d);
        issue(OP_SET_BP, b, 32'd0);
        e0 = en_cnt;
        issue(OP_RUN, 8'd0, 32'd0);
        repeat (d) @(posedge clk);
        issue(OP_HALT, 8'd0, 32'd0);
        total++; if ({halted, bp_hit} !== 2'b11 || pc !== b) begin bad++; $display("FAIL halt_bp_same halt/hit/pc got=%b%b/%0d exp=11/%0d", halted, bp_hit, pc, b); end
        total++; if (en_cnt - e0 !== d) begin bad++; $display("FAIL halt_bp_same_count got=%0d exp=%0d", en_cnt - e0, d); end
    endtask

    task automatic test_reset_cpu();
        int e0;
        issue(OP_SET_BP, 8'd4, 32'd0);
        issue(OP_RESET_CPU, 8'd0, 32'd0);
        total++; if ({cpu_rst_n, cmd_ready, bp_hit} !== 3'b000) begin bad++; $display("FAIL crst_t1 rstn/ready/hit got=%b exp=000", {cpu_rst_n, cmd_ready, bp_hit}); end
        total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL crst_instr_cnt got=%0d exp=0", instr_cnt); end
        @(posedge clk); #1;
        total++; if ({cpu_rst_n, cmd_ready, halted} !== 3'b111 || pc !== 8'd0) begin bad++; $display("FAIL crst_t2 got=%b pc=%0d exp=111 pc=0", {cpu_rst_n, cmd_ready, halted}, pc); end
        e0 = en_cnt;
        issue(OP_RUN, 8'd0, 32'd0);
        wait_halted();
        total++; if (en_cnt - e0 !== 4 || pc !== 8'd4 || bp_hit !== 1'b1) begin bad++; $display("FAIL crst_bp_kept got=%0d/%0d/%b exp=4/4/1", en_cnt - e0, pc, bp_hit); end
        issue(OP_RUN, 8'd0, 32'd0);
        total++; if ({cpu_en, bp_hit} !== 2'b10 || pc !== 8'd4) begin bad++; $display("FAIL crst_resume en/hit/pc got=%b%b/%0d exp=10/4", cpu_en, bp_hit, pc); end
        issue(OP_HALT, 8'd0, 32'd0);
    endtask

    task automatic test_instr_cnt();
        logic [31:0] exp;
`ifdef SR_RUN_CTRL_INSTR_CNT_EN
        exp = 32'd15;
`else
        exp = 32'd0;
`endif
        issue(OP_CLR_BP, 8'd0, 32'd0);
        issue(OP_RESET_CPU, 8'd0, 32'd0);
        issue(OP_STEP, 8'd0, 32'd5);
        wait_halted();
        issue(OP_RUN, 8'd0, 32'd0);
        repeat (10) @(posedge clk);
        issue(OP_HALT, 8'd0, 32'd0);
        total++; if (instr_cnt !== exp) begin bad++; $display("FAIL instr_cnt got=%0d exp=%0d", instr_cnt, exp); end
        issue(OP_RESET_CPU, 8'd0, 32'd0);
        total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL instr_cnt_clr got=%0d exp=0", instr_cnt); end
    endtask

    task automatic test_reset_abort();
        issue(OP_SET_BP, 8'd20, 32'd0);
        issue(OP_RUN, 8'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({halted, cpu_en, cpu_rst_n, bp_hit} !== 4'b1000) begin bad++; $display("FAIL abort got=%b exp=1000", {halted, cpu_en, cpu_rst_n, bp_hit}); end
        total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL abort_instr_cnt got=%0d exp=0", instr_cnt); end
        @(negedge clk);
        rst = 1'b0;
        issue(OP_RUN, 8'd0, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        total++; if ({halted, bp_hit} !== 2'b00 || pc !== 8'd30) begin bad++; $display("FAIL abort_bp_gone got=%b%b/%0d exp=00/30", halted, bp_hit, pc); end
        issue(OP_HALT, 8'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_breakpoint();
        test_step_bp();
        test_run_err();
        test_halt_bp_same();
        test_reset_cpu();
        test_instr_cnt();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_run_ctrl.md
Name: sr_run_ctrl

Overview:
Run-control sequencer for the single-cycle RISC-V core.
- Owns the core's reset and execution enable; provides halt, run and N-instruction step.
- Provides one instruction breakpoint.
- Shares the instruction-memory write port with the core: a host can load program words only while the core is halted.
- Sits between a host command port (debug/UART bridge) and the sr_cpu/instruction-memory pair.

Parameters:
AW, 8, instruction-memory word-address width (matches imAddr word indexing).
STEP_W, 16, width of the step count.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 LOAD, 7 RESET_CPU
cmd_addr  in  AW  breakpoint/load word address
cmd_data  in  32  load data; STEP uses [STEP_W-1:0] as count
cmd_err  out  1  one-cycle pulse when an accepted op is illegal in the current state
cpu_pc  in  AW  core's current instruction word address (imAddr[AW-1:0])
cpu_en  out  1  core executes/retires the current instruction this cycle (gates PC and register-file writes)
cpu_rst_n  out  1  core reset, active low
imem_we  out  1  instruction-memory write strobe
imem_waddr  out  AW  write address
imem_wdata  out  32  write data
halted  out  1  state == HALTED
bp_hit  out  1  sticky: last halt was caused by the breakpoint
instr_cnt  out  32  retired-instruction count (optional feature)

Behaviour:
- Reset values: state HALTED, cpu_en=0, cpu_rst_n=0, imem_we=0, imem_waddr=0, imem_wdata=0, cmd_err=0, bp_hit=0, breakpoint invalid, step counter=0, instr_cnt=0.
- cpu_rst_n goes to 1 on the first cycle after rst deasserts.
- Reset asserted mid-operation (RUN/STEP/LOAD) aborts immediately and returns everything to these reset values.
- States: HALTED, RUN, STEP, LOAD, CRST.
- cmd_ready=1 in HALTED and RUN; 0 in STEP, LOAD, CRST.
- In RUN only NOP and HALT are legal; any other accepted op -> cmd_err pulse next cycle, state unchanged.
- In HALTED all ops are legal; HALT is a no-op.
- cpu_en is combinational:
  - RUN: 1 unless breakpoint match.
  - STEP: 1 unless breakpoint match.
  - Otherwise 0.
- Breakpoint match = bp_valid && cpu_pc==bp_addr && !first.
  - first is set on entry to RUN/STEP and cleared after the first cpu_en cycle. Resuming from a breakpoint therefore executes the breakpoint instruction.
- RUN -> HALTED:
  - On accepted HALT: cpu_en=0 in the acceptance cycle.
  - On match: that instruction is not executed, bp_hit<=1.
  - HALT and match in the same cycle -> HALTED with bp_hit=1.
- HALTED + RUN -> RUN next cycle; bp_hit<=0.
- HALTED + STEP:
  - Count N = cmd_data[STEP_W-1:0]; N=0 is treated as 1.
  - STEP for exactly N cpu_en cycles, then HALTED. Counter decrements per cpu_en cycle.
  - A match in STEP halts early (remaining count discarded, bp_hit<=1).
  - bp_hit<=0 on entry.
- SET_BP: bp_addr<=cmd_addr, bp_valid<=1. CLR_BP: bp_valid<=0. Both take 1 cycle, no state change.
- LOAD accepted at cycle T:
  - imem_we=1 with registered addr/data at T+1 (state LOAD).
  - Back to HALTED at T+2.
  - LOAD to the current PC address is permitted.
- RESET_CPU accepted at T: cpu_rst_n=0 at T+1 (state CRST), HALTED at T+2. Breakpoint retained; bp_hit cleared.
- Step counter arithmetic is STEP_W bits, no wrap: decrement only when nonzero.

Optional Feature:
SR_RUN_CTRL_INSTR_CNT_EN
- Defined: instr_cnt increments by 1 on every cycle with cpu_en=1 and wraps at 2^32. Cleared by rst and by RESET_CPU (at T+1).
- Undefined: no counter register; instr_cnt tied to 0.

Decomposition:
- Shared header (alongside sr_cpu.vh): `define constants for the cmd_op encodings and the state encodings.
- One natural sub-module: sr_bp_unit. It holds bp_addr/bp_valid/first and outputs the match flag.
- Step counter and FSM stay in sr_run_ctrl.

Test Plan:
- Reset release: cpu_rst_n=0 during rst, 1 next cycle; halted=1; cpu_en=0 until RUN accepted.
- LOAD addr 0x05 data 0x00500093 accepted at T -> imem_we=1, waddr=0x05, wdata=0x00500093 only at T+1; cmd_ready=0 at T+1, 1 at T+2.
- STEP N=3 from pc 0 -> exactly 3 cpu_en cycles, then halted=1; STEP N=0 -> exactly 1 cycle.
- SET_BP 0x04, RUN from pc 0 -> cpu_en cycles at pc 0..3; at pc 4 cpu_en=0, halted=1, bp_hit=1. A further RUN executes pc 4 and bp_hit clears.
- In RUN, issue LOAD -> cmd_err pulse, no imem_we, still running. HALT in the same cycle as a breakpoint match -> halted, bp_hit=1.
- With SR_RUN_CTRL_INSTR_CNT_EN: STEP 5, then RUN 10 cycles, then HALT -> instr_cnt=15; RESET_CPU -> 0.
